// File: rtl/uart_rx_pkg.sv
// Shared types and limits for the UART receive controller.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_CHK,
    DATA,
    STOP,
    LOAD,
    WAIT_IDLE
  } rx_state_t;

  localparam int BP_MIN        = 4;
  localparam int DATA_SIZE_MIN = 5;
  localparam int DATA_SIZE_MAX = 8;

  // Out-of-range character sizes fall back to a full byte.
  function automatic logic [3:0] clamp_size(input logic [3:0] ds);
    if (ds < 4'(DATA_SIZE_MIN) || ds > 4'(DATA_SIZE_MAX)) return 4'(DATA_SIZE_MAX);
    return ds;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_flex_counter.sv
// Clearable up-counter that wraps from rollover_val back to 1 and flags the terminal count.
module flex_counter #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clear,
  input  logic         count_enable,
  input  logic [W-1:0] rollover_val,
  output logic         rollover_flag
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear)
      count_d = '0;
    else if (count_enable)
      count_d = (count_q == rollover_val) ? W'(1) : count_q + W'(1);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) count_q <= '0;
    else        count_q <= count_d;
  end

  assign rollover_flag = (count_q == rollover_val);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: finds the start bit, strobes a downstream SIPO at each
// data-bit centre and checks the stop bit.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int BP_BITS = 14
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               serial_in,
  input  logic [BP_BITS-1:0] bit_period,
  input  logic [3:0]         data_size,
  output logic               shift_strobe,
  output logic               load_buffer,
  output logic               framing_error,
  output logic               receiving
);

  rx_state_t          state_q, state_d;
  logic               sin_q;
  logic [BP_BITS-1:0] per_q, per_d;
  logic [3:0]         size_q, size_d;
  logic [3:0]         bits_q, bits_d;
  logic               ferr_q, ferr_d;
  logic               cnt_clr, cnt_en, cnt_roll;
  logic [BP_BITS-1:0] roll_val;

  flex_counter #(.W(BP_BITS)) u_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (cnt_clr),
    .count_enable (cnt_en),
    .rollover_val (roll_val),
    .rollover_flag(cnt_roll)
  );

  always_comb begin
    state_d      = state_q;
    per_d        = per_q;
    size_d       = size_q;
    bits_d       = bits_q;
    ferr_d       = ferr_q;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;
    roll_val     = per_q;
    shift_strobe = 1'b0;
    load_buffer  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sin_q && !serial_in) begin
          state_d = START_CHK;
          cnt_clr = 1'b1;
          bits_d  = '0;
          per_d   = (bit_period < BP_BITS'(BP_MIN)) ? BP_BITS'(BP_MIN) : bit_period;
          size_d  = clamp_size(data_size);
        end
      end
      START_CHK: begin
        // Counter starts at 0 here, so terminal count P/2-1 spans P/2 cycles;
        // the wrap to 1 then lines DATA up on a full-period grid.
        cnt_en   = 1'b1;
        roll_val = (per_q >> 1) - BP_BITS'(1);
        if (cnt_roll) state_d = serial_in ? IDLE : DATA;
      end
      DATA: begin
        cnt_en = 1'b1;
        if (cnt_roll) begin
          shift_strobe = 1'b1;
          bits_d       = bits_q + 4'd1;
          if (bits_q + 4'd1 == size_q) state_d = STOP;
        end
      end
      STOP: begin
        cnt_en = 1'b1;
        if (cnt_roll) begin
          ferr_d  = !serial_in;
          state_d = serial_in ? LOAD : WAIT_IDLE;
        end
      end
      LOAD: begin
        load_buffer = 1'b1;
        state_d     = IDLE;
      end
      WAIT_IDLE: begin
        if (serial_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      sin_q   <= 1'b1;
      per_q   <= BP_BITS'(BP_MIN);
      size_q  <= 4'(DATA_SIZE_MAX);
      bits_q  <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sin_q   <= serial_in;
      per_q   <= per_d;
      size_q  <= size_d;
      bits_q  <= bits_d;
      ferr_q  <= ferr_d;
    end
  end

  assign framing_error = ferr_q;
  assign receiving     = (state_q != IDLE);

endmodule
